// File: rtl/sid_pkg.sv
// sid_pkg: shared constants for the SID bus interface.
//   - SID register-space constants
//   - access FSM state encoding used by sid_bus_cycle
package sid_pkg;

  // The 6581/8580 decodes 29 registers (0x00..0x1C) in a 5-bit address space.
  localparam int unsigned SID_NUM_REGS = 29;
  localparam int unsigned SID_ADDR_W   = 5;
  localparam int unsigned SID_DATA_W   = 8;

  // Access FSM states.
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StArm   = 3'd1;
  localparam logic [2:0] StSetup = 3'd2;
  localparam logic [2:0] StHigh  = 3'd3;
  localparam logic [2:0] StHold  = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

endpackage

// File: rtl/sid_phi2_gen.sv
// sid_phi2_gen: free-running PHI2 generator.
//   i_clk      system clock (rising edge)
//   i_rst_n    asynchronous active-low reset
//   o_phi2     registered PHI2, toggles every PHI2_HALF clocks
//   o_rise_ev  high on the last PHI2-low clock (PHI2 rises at the next edge)
//   o_fall_ev  high on the last PHI2-high clock (PHI2 falls at the next edge)
module sid_phi2_gen #(
  parameter int unsigned PHI2_HALF = 25
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_phi2,
  output logic o_rise_ev,
  output logic o_fall_ev
);

  localparam logic [7:0] CntMax = 8'(PHI2_HALF - 1);

  logic [7:0] r_cnt;
  logic       r_phi2;
  logic       w_wrap;

  assign w_wrap = (r_cnt == CntMax);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= 8'd0;
      r_phi2 <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= 8'd0;
      r_phi2 <= ~r_phi2;
    end else begin
      r_cnt  <= r_cnt + 8'd1;
    end
  end

  assign o_phi2    = r_phi2;
  assign o_rise_ev = ~r_phi2 & w_wrap;
  assign o_fall_ev = r_phi2 & w_wrap;

endmodule

// File: rtl/sid_bus_cycle.sv
// sid_bus_cycle: turns a level request from the Z3 slave decode into one
// PHI2-phased SID bus cycle and returns a level acknowledge.
//   CLK, RESET_n         clock / asynchronous active-low reset
//   SID_REQ, READ, ADDR, WDATA   request and its attributes (sampled in idle)
//   SID_ACK, RDATA       completion handshake and read byte
//   SID_PHI2, SID_CS_n, SID_RW, SID_A, SID_D_OUT, SID_D_OE, SID_D_IN   SID pins
// All SID-facing outputs are registered; they are computed from the next state
// so that CS_n is low for exactly the SETUP+HIGH states.
module sid_bus_cycle
  import sid_pkg::*;
#(
  parameter int unsigned PHI2_HALF = 25
) (
  input  logic                  CLK,
  input  logic                  RESET_n,
  input  logic                  SID_REQ,
  input  logic                  READ,
  input  logic [SID_ADDR_W-1:0] ADDR,
  input  logic [SID_DATA_W-1:0] WDATA,
  output logic                  SID_ACK,
  output logic [SID_DATA_W-1:0] RDATA,
  output logic                  SID_PHI2,
  output logic                  SID_CS_n,
  output logic                  SID_RW,
  output logic [SID_ADDR_W-1:0] SID_A,
  output logic [SID_DATA_W-1:0] SID_D_OUT,
  output logic                  SID_D_OE,
  input  logic [SID_DATA_W-1:0] SID_D_IN
);

  logic                  w_rise_ev;
  logic                  w_fall_ev;
  logic [2:0]            r_state;
  logic [2:0]            w_state_d;
  logic                  r_read;
  logic [SID_ADDR_W-1:0] r_addr;
  logic [SID_DATA_W-1:0] r_wdata;
  logic                  r_ack;
  logic [SID_DATA_W-1:0] r_rdata;
  logic                  r_cs_n;
  logic                  r_rw;
  logic [SID_ADDR_W-1:0] r_a;
  logic [SID_DATA_W-1:0] r_dout;
  logic                  r_oe;

  sid_phi2_gen #(
    .PHI2_HALF (PHI2_HALF)
  ) u_phi2 (
    .i_clk     (CLK),
    .i_rst_n   (RESET_n),
    .o_phi2    (SID_PHI2),
    .o_rise_ev (w_rise_ev),
    .o_fall_ev (w_fall_ev)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (SID_REQ && !r_ack) w_state_d = StArm;
      StArm:   if (w_fall_ev) w_state_d = StSetup;
      StSetup: if (w_rise_ev) w_state_d = StHigh;
      StHigh:  if (w_fall_ev) w_state_d = StHold;
      // A request dropped mid-cycle (Z3 abort) finishes silently with no ack.
      StHold:  w_state_d = SID_REQ ? StDone : StIdle;
      StDone:  if (!SID_REQ) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state <= StIdle;
      r_read  <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_cs_n  <= 1'b1;
      r_rw    <= 1'b1;
      r_a     <= '0;
      r_dout  <= '0;
      r_oe    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cs_n  <= !(w_state_d == StSetup || w_state_d == StHigh);
      r_ack   <= (w_state_d == StDone);

      if (r_state == StIdle && w_state_d == StArm) begin
        r_read  <= READ;
        r_addr  <= ADDR;
        r_wdata <= WDATA;
      end

      // Bus attributes go out with CS and stay through HOLD for hold time.
      if (r_state == StArm && w_state_d == StSetup) begin
        r_a  <= r_addr;
        r_rw <= r_read;
        if (!r_read) begin
          r_dout <= r_wdata;
          r_oe   <= 1'b1;
        end
      end

      if (r_state == StHold) begin
        r_oe <= 1'b0;
        r_rw <= 1'b1;
      end

      // Last PHI2-high clock: SID read data is valid here.
      if (r_state == StHigh && w_fall_ev && r_read) begin
        r_rdata <= SID_D_IN;
      end
    end
  end

  assign SID_ACK   = r_ack;
  assign RDATA     = r_rdata;
  assign SID_CS_n  = r_cs_n;
  assign SID_RW    = r_rw;
  assign SID_A     = r_a;
  assign SID_D_OUT = r_dout;
  assign SID_D_OE  = r_oe;

endmodule

// File: tb/tb_sid_bus_cycle.sv
// tb_sid_bus_cycle: directed bench for sid_bus_cycle with PHI2_HALF=4.
// The bench tracks the PHI2 phase itself by counting clock edges since reset
// release: after edge n, cnt = n % H and PHI2 = (n / H) % 2.
module tb_sid_bus_cycle;

  localparam int H = 4;

  logic       CLK = 1'b0;
  logic       RESET_n = 1'b0;
  logic       SID_REQ = 1'b0;
  logic       READ = 1'b0;
  logic [4:0] ADDR = 5'd0;
  logic [7:0] WDATA = 8'd0;
  logic [7:0] SID_D_IN = 8'd0;
  logic       SID_ACK;
  logic [7:0] RDATA;
  logic       SID_PHI2;
  logic       SID_CS_n;
  logic       SID_RW;
  logic [4:0] SID_A;
  logic [7:0] SID_D_OUT;
  logic       SID_D_OE;

  int n_cmp = 0;
  int n_err = 0;
  int n = 0;

  sid_bus_cycle #(
    .PHI2_HALF (H)
  ) dut (
    .CLK       (CLK),
    .RESET_n   (RESET_n),
    .SID_REQ   (SID_REQ),
    .READ      (READ),
    .ADDR      (ADDR),
    .WDATA     (WDATA),
    .SID_ACK   (SID_ACK),
    .RDATA     (RDATA),
    .SID_PHI2  (SID_PHI2),
    .SID_CS_n  (SID_CS_n),
    .SID_RW    (SID_RW),
    .SID_A     (SID_A),
    .SID_D_OUT (SID_D_OUT),
    .SID_D_OE  (SID_D_OE),
    .SID_D_IN  (SID_D_IN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    n++;
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RESET_n = 1'b1;
    n = 0;
  endtask

  // One request. s = edge after which CS goes low. drop_rel >= 0 drops REQ
  // after edge s+drop_rel (abort); rst_rel >= 0 pulses reset after edge
  // s+rst_rel. Otherwise REQ is held until the ack is seen, then released.
  task automatic access(input bit rd, input logic [4:0] ad, input logic [7:0] wd,
                        input logic [7:0] din, input int drop_rel, input int rst_rel);
    int  m;
    int  s;
    bit  held;
    held     = (drop_rel < 0);
    SID_REQ  = 1'b1;
    READ     = rd;
    ADDR     = ad;
    WDATA    = wd;
    SID_D_IN = ~din;
    // REQ is sampled at edge n+1; ARM then waits for a FALL_EV cycle
    // (the cycle after an edge m with m % 2H == 2H-1).
    m = n + 1;
    while (m % (2 * H) != 2 * H - 1) m++;
    s = m + 1;
    while (n < s + 2 * H + 3) begin
      tick();
      // Only the last PHI2-high cycle carries the real read byte.
      SID_D_IN = (n == s + 2 * H - 1) ? din : ~din;
      check("phi2", SID_PHI2, (n / H) % 2);
      check("cs_n", SID_CS_n, !(n >= s && n < s + 2 * H));
      if (n >= s && n <= s + 2 * H) begin
        check("sid_a", SID_A, ad);
        check("sid_rw", SID_RW, rd);
        if (!rd) begin
          check("d_oe", SID_D_OE, 1);
          check("d_out", SID_D_OUT, wd);
        end
      end
      if (n <= s + 2 * H) check("ack_early", SID_ACK, 0);
      if (n == s + 2 * H + 1) begin
        check("ack", SID_ACK, held);
        check("oe_done", SID_D_OE, 0);
        check("rw_done", SID_RW, 1);
        if (rd) check("rdata", RDATA, din);
      end
      if (n == s + 2 * H + 2) check("ack_hold", SID_ACK, held);
      if (n == s + 2 * H + 3) check("ack_fall", SID_ACK, 0);
      if (held && n == s + 2 * H + 2) SID_REQ = 1'b0;
      if (!held && n == s + drop_rel) SID_REQ = 1'b0;
      if (rst_rel >= 0 && n == s + rst_rel) begin
        SID_REQ = 1'b0;
        #2;
        RESET_n = 1'b0;
        #1;
        check("rst_cs_n", SID_CS_n, 1);
        check("rst_oe", SID_D_OE, 0);
        check("rst_phi2", SID_PHI2, 0);
        check("rst_ack", SID_ACK, 0);
        release_reset();
        return;
      end
    end
  endtask

  initial begin
    // Reset values.
    #12;
    check("rst_phi2", SID_PHI2, 0);
    check("rst_cs_n", SID_CS_n, 1);
    check("rst_rw", SID_RW, 1);
    check("rst_a", SID_A, 0);
    check("rst_dout", SID_D_OUT, 0);
    check("rst_oe", SID_D_OE, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_ack", SID_ACK, 0);
    release_reset();

    // Free-running PHI2, no requests: period 2H, single-cycle events.
    for (int i = 0; i < 4 * H; i++) begin
      tick();
      check("phi2_free", SID_PHI2, (n / H) % 2);
      check("cs_idle", SID_CS_n, 1);
      check("rise_ev", dut.u_phi2.o_rise_ev, ((n / H) % 2 == 0) && (n % H == H - 1));
      check("fall_ev", dut.u_phi2.o_fall_ev, ((n / H) % 2 == 1) && (n % H == H - 1));
    end

    // Read 0x1B, SID returns 0x5A.
    access(1'b1, 5'h1B, 8'h00, 8'h5A, -1, -1);
    // REQ is low now: nothing must restart.
    for (int i = 0; i < 2 * H; i++) begin
      tick();
      check("no_rerun_cs", SID_CS_n, 1);
      check("no_rerun_ack", SID_ACK, 0);
    end

    // Write 0x0F to 0x18.
    access(1'b0, 5'h18, 8'h0F, 8'h00, -1, -1);
    check("rdata_kept", RDATA, 8'h5A);

    // Request first seen on a FALL_EV cycle: that edge is missed, so CS drops
    // 2H+1 edges later and the ack comes 4H+2 edges after the sampling cycle
    // (19 cycles counting the sampling cycle itself).
    while (n % (2 * H) != 2 * H - 1) tick();
    access(1'b1, 5'h0A, 8'h00, 8'h77, -1, -1);

    // Abort: REQ dropped during HIGH; cycle completes, no ack.
    access(1'b1, 5'h11, 8'h00, 8'hC3, H + 1, -1);
    for (int i = 0; i < 2 * H; i++) begin
      tick();
      check("abort_idle_cs", SID_CS_n, 1);
      check("abort_idle_ack", SID_ACK, 0);
    end

    // Reset pulsed during the HIGH phase of a write, then a normal read.
    access(1'b0, 5'h02, 8'h99, 8'h00, -1, H + 1);
    access(1'b1, 5'h04, 8'h00, 8'h3C, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
